// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache and the memory-stage alignment logic.
package dcache_pkg;

    // Cache controller states
    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWriteback = 2'd1;
    localparam logic [1:0] StRefill    = 2'd2;

    // Load/store size and sign encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the word-offset field within a line
    function automatic int unsigned off_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Width of the set-index field
    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte/half/word alignment: load extract with sign/zero extension and
// store lane merge into an existing word. Used by both the cache and the flat data memory.
module mem_align
    import dcache_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wword_o
);

    logic [4:0]  byte_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend for loads or merge for stores
    always_comb begin
        byte_sh  = {addr_lo_i, 3'b000};
        byte_sel = rword_i[byte_sh +: 8];
        // Half access ignores addr[0]; misalignment is not trapped
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        case (ctrl_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            default: rdata_o = rword_i;
        endcase

        wword_o = rword_i;
        case (ctrl_i)
            F3_B, F3_BU: wword_o[byte_sh +: 8] = wdata_i[7:0];
            F3_H, F3_HU: begin
                if (addr_lo_i[1]) begin
                    wword_o[31:16] = wdata_i[15:0];
                end else begin
                    wword_o[15:0] = wdata_i[15:0];
                end
            end
            default:     wword_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Write-back set-associative data cache (1 or 2 ways). Hits complete combinationally;
// misses stall the pipeline while lines are written back and refilled word by word.
module data_cache
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SETS           = 16,
    parameter int unsigned WAYS           = 2,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [2:0]            cpu_ctrl_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int unsigned OffW    = off_w(WORDS_PER_LINE);
    localparam int unsigned IdxW    = idx_w(SETS);
    localparam int unsigned CntW    = (OffW > 0) ? OffW : 1;
    localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LineLsb = OffW + 2;
    localparam int unsigned TagLsb  = IdxW + OffW + 2;
    localparam int unsigned TagW    = ADDR_WIDTH - TagLsb;
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        ~((ADDR_WIDTH'(1) << LineLsb) - ADDR_WIDTH'(1));
    localparam logic [CntW-1:0] LastWord = CntW'(WORDS_PER_LINE - 1);

    logic [TagW-1:0]       tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][WORDS_PER_LINE];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WayW-1:0] victim_q, victim_d;

    logic [IdxW-1:0]       idx;
    logic [TagW-1:0]       req_tag;
    logic [CntW-1:0]       word_off;
    logic                  hit;
    logic [WayW-1:0]       hit_way;
    logic [WayW-1:0]       victim;
    logic                  lru_cur;
    logic                  lookup_hit, store_hit, refill_ack, refill_done, last;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [ADDR_WIDTH-1:0] line_off;

    assign idx      = cpu_addr_i[TagLsb-1:LineLsb];
    assign req_tag  = cpu_addr_i[ADDR_WIDTH-1:TagLsb];
    assign word_off = CntW'(cpu_addr_i >> 2) & LastWord;
    assign line_off = ADDR_WIDTH'(cnt_q) << 2;
    assign last     = (cnt_q == LastWord);

    // Tag compare across all ways of the indexed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][WayW'(w)] && (tag_q[w][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the LRU way
    always_comb begin
        victim = WayW'(lru_cur);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][WayW'(w)]) begin
                victim = WayW'(w);
            end
        end
    end

    assign lookup_hit  = (state_q == StIdle) && cpu_req_i && hit;
    assign store_hit   = lookup_hit && cpu_we_i;
    assign refill_ack  = (state_q == StRefill) && mem_ack_i;
    assign refill_done = refill_ack && last;

    assign cpu_stall_o = cpu_req_i && ((state_q != StIdle) || !hit);

    mem_align u_align (
        .ctrl_i    (cpu_ctrl_i),
        .addr_lo_i (cpu_addr_i[1:0]),
        .rword_i   (data_q[hit_way][idx][word_off]),
        .wdata_i   (cpu_wdata_i),
        .rdata_o   (cpu_rdata_o),
        .wword_o   (merged_word)
    );

    // Memory port is driven purely from the transfer state; idle drives zeros
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            StWriteback: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = (ADDR_WIDTH'(tag_q[victim_q][idx]) << TagLsb)
                            | (ADDR_WIDTH'(idx) << LineLsb) | line_off;
                mem_wdata_o = data_q[victim_q][idx][cnt_q];
            end
            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = (cpu_addr_i & LineMask) | line_off;
            end
            default: ;
        endcase
    end

    // Next-state: miss detection in idle, word counter advanced by each ack
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        victim_d = victim_q;
        case (state_q)
            StIdle: begin
                if (cpu_req_i && !hit) begin
                    victim_d = victim;
                    cnt_d    = '0;
                    state_d  = (valid_q[idx][victim] && dirty_q[idx][victim]) ?
                               StWriteback : StRefill;
                end
            end
            StWriteback: begin
                if (mem_ack_i) begin
                    cnt_d = last ? '0 : cnt_q + CntW'(1);
                    if (last) state_d = StRefill;
                end
            end
            StRefill: begin
                if (mem_ack_i) begin
                    cnt_d = last ? '0 : cnt_q + CntW'(1);
                    if (last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller registers; reset abandons any transfer in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

    // Valid/dirty bookkeeping; reset invalidates every line, discarding dirty data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (store_hit) begin
            dirty_q[idx][hit_way] <= 1'b1;
        end else if (refill_done) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            data_q[hit_way][idx][word_off] <= merged_word;
        end
        if (refill_ack) begin
            data_q[victim_q][idx][cnt_q] <= mem_rdata_i;
        end
        if (refill_done) begin
            tag_q[victim_q][idx] <= req_tag;
        end
    end

    if (WAYS > 1) begin : g_lru
        logic [SETS-1:0] lru_q;

        // LRU bit names the way to evict next: any hit points it at the other way
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                lru_q <= '0;
            end else if (lookup_hit) begin
                lru_q[idx] <= ~hit_way[0];
            end
        end

        assign lru_cur = lru_q[idx];
    end else begin : g_no_lru
        assign lru_cur = 1'b0;
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomised scoreboard bench: a 2-way cache and a direct-mapped 4-set cache are both
// checked against a flat byte-addressable memory model.
module tb_data_cache;
    import dcache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, sel, we;
    logic [2:0]  ctrl;
    logic [31:0] addr, wdata;

    logic [31:0] a_rdata, a_maddr, a_mwdata, b_rdata, b_maddr, b_mwdata, m_rdata;
    logic        a_stall, a_mreq, a_mwe, b_stall, b_mreq, b_mwe, m_ack;

    data_cache u_dut_a (
        .clk_i (clk), .rst_ni (rst_n),
        .cpu_req_i (req & ~sel), .cpu_we_i (we), .cpu_ctrl_i (ctrl),
        .cpu_addr_i (addr), .cpu_wdata_i (wdata),
        .cpu_rdata_o (a_rdata), .cpu_stall_o (a_stall),
        .mem_req_o (a_mreq), .mem_we_o (a_mwe), .mem_addr_o (a_maddr),
        .mem_wdata_o (a_mwdata), .mem_rdata_i (m_rdata), .mem_ack_i (m_ack & ~sel)
    );

    data_cache #(.SETS(4), .WAYS(1)) u_dut_b (
        .clk_i (clk), .rst_ni (rst_n),
        .cpu_req_i (req & sel), .cpu_we_i (we), .cpu_ctrl_i (ctrl),
        .cpu_addr_i (addr), .cpu_wdata_i (wdata),
        .cpu_rdata_o (b_rdata), .cpu_stall_o (b_stall),
        .mem_req_o (b_mreq), .mem_we_o (b_mwe), .mem_addr_o (b_maddr),
        .mem_wdata_o (b_mwdata), .mem_rdata_i (m_rdata), .mem_ack_i (m_ack & sel)
    );

    logic [31:0] rdata, m_addr, m_wdata;
    logic        stall, m_req, m_we;
    assign rdata   = sel ? b_rdata  : a_rdata;
    assign stall   = sel ? b_stall  : a_stall;
    assign m_req   = sel ? b_mreq   : a_mreq;
    assign m_we    = sel ? b_mwe    : a_mwe;
    assign m_addr  = sel ? b_maddr  : a_maddr;
    assign m_wdata = sel ? b_mwdata : a_mwdata;

    int n_cmp = 0;
    int n_err = 0;
    bit rand_lat = 1'b0;

    logic [31:0] exp_q [$];
    logic [31:0] bmem    [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
    } xfer_t;
    xfer_t xlog [$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Flat-memory load semantics
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = ref_rd({a[31:2], 2'b00});
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b < 128) ? b : (b | 32'hFFFF_FF00);
            3'b001:  return (h < 32768) ? h : (h | 32'hFFFF_0000);
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa, w;
        int unsigned sh;
        wa = {a[31:2], 2'b00};
        w  = ref_rd(wa);
        case (f3)
            3'b000: begin
                sh = 8 * a[1:0];
                w  = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end
            3'b001: begin
                sh = 16 * a[1];
                w  = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            end
            default: w = d;
        endcase
        ref_mem[wa] = w;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic abort(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no completion within cycle bound at %0t", nm, $time);
        summary_and_finish();
    endtask

    // Monitor: every completed load pops the scoreboard
    always @(negedge clk) begin
        if (rst_n && req && !stall && !we) begin
            if (exp_q.size() == 0) begin
                check("load_unexpected", 64'(rdata), 64'hFFFF_FFFF_0000_0000);
            end else begin
                check("load_data", 64'(rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    // Backing memory: optional random latency, outputs must hold until ack
    initial begin : responder
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        bit          busy;
        int          dly;
        m_ack   = 1'b0;
        m_rdata = '0;
        busy    = 1'b0;
        dly     = 0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (rst_n && m_req) begin
                if (!busy) begin
                    busy    = 1'b1;
                    h_addr  = m_addr;
                    h_we    = m_we;
                    h_wdata = m_wdata;
                    dly     = rand_lat ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    check("mem_addr_hold", 64'(m_addr), 64'(h_addr));
                    check("mem_we_hold", 64'(m_we), 64'(h_we));
                    if (h_we) check("mem_wdata_hold", 64'(m_wdata), 64'(h_wdata));
                end
                if (dly == 0) begin
                    if (h_we) bmem[h_addr] = h_wdata;
                    else m_rdata = bmem_rd(h_addr);
                    xlog.push_back({h_we, h_addr});
                    m_ack = 1'b1;
                    busy  = 1'b0;
                end else begin
                    dly--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Issue one access and hold it until the cache stops stalling
    task automatic do_op(input bit s, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, output int stalls);
        sel = s; we = w; ctrl = f3; addr = a; wdata = d; req = 1'b1;
        if (w) model_store(f3, a, d);
        else exp_q.push_back(model_load(f3, a));
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 400) abort("op_timeout");
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic check_line(input string nm, input int pos, input bit w, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            if (pos + k < xlog.size()) begin
                check(nm, {31'b0, xlog[pos + k].we, xlog[pos + k].addr},
                      {31'b0, w, base + 32'(4 * k)});
            end
        end
    endtask

    logic [2:0] ld_ops [5];
    logic [2:0] st_ops [3];

    initial begin : stim
        int st;
        logic [31:0] a;
        ld_ops = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_ops = '{F3_B, F3_H, F3_W};
        rst_n = 1'b0; req = 1'b0; sel = 1'b0; we = 1'b0; ctrl = F3_W; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(a_stall), 64'd0);
        check("reset_mem_req", 64'(a_mreq), 64'd0);
        check("reset_mem_we", 64'(a_mwe), 64'd0);
        check("reset_mem_req_b", 64'(b_mreq), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold load: 4 refill reads then hit
        xlog.delete();
        do_op(0, 0, F3_W, 32'h100, 0, st);
        check("cold_stall", 64'(st), 64'd5);
        check("cold_xfers", 64'(xlog.size()), 64'd4);
        check_line("cold_refill_addr", 0, 1'b0, 32'h100);

        do_op(0, 1, F3_B, 32'h103, 32'h0000_00AB, st);
        check("sb_hit_stall", 64'(st), 64'd0);
        do_op(0, 0, F3_W, 32'h100, 0, st);
        do_op(0, 0, F3_B, 32'h103, 0, st);
        check("lb_hit_stall", 64'(st), 64'd0);

        // Conflicts in set 0: clean LRU victim, then dirty LRU victim
        do_op(0, 0, F3_W, 32'h200, 0, st);
        check("second_way_stall", 64'(st), 64'd5);
        do_op(0, 0, F3_W, 32'h100, 0, st);
        check("rehit_stall", 64'(st), 64'd0);
        xlog.delete();
        do_op(0, 0, F3_W, 32'h300, 0, st);
        check("clean_evict_stall", 64'(st), 64'd5);
        check("clean_evict_xfers", 64'(xlog.size()), 64'd4);
        check_line("clean_evict_refill", 0, 1'b0, 32'h300);
        xlog.delete();
        do_op(0, 0, F3_W, 32'h400, 0, st);
        check("dirty_evict_stall", 64'(st), 64'd9);
        check("dirty_evict_xfers", 64'(xlog.size()), 64'd8);
        check_line("dirty_writeback", 0, 1'b1, 32'h100);
        check_line("dirty_refill", 4, 1'b0, 32'h400);
        do_op(0, 0, F3_W, 32'h100, 0, st);
        do_op(0, 0, F3_BU, 32'h103, 0, st);

        // Random traffic over 6 tags x 4 sets with random memory latency
        rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 32'h1000 | (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) do_op(0, 1, st_ops[$urandom_range(0, 2)], a, $urandom, st);
            else do_op(0, 0, ld_ops[$urandom_range(0, 4)], a, 0, st);
        end

        // Reset while refilling word 2: transfer abandoned, all lines invalid
        rand_lat = 1'b0;
        do_op(0, 0, F3_W, 32'h100, 0, st);
        do_op(0, 0, F3_W, 32'h100, 0, st);
        check("hit_before_reset", 64'(st), 64'd0);
        sel = 1'b0; we = 1'b0; ctrl = F3_W; addr = 32'h2050; req = 1'b1;
        st = 0;
        forever begin
            @(negedge clk);
            if (m_req && !m_we && m_addr == 32'h2058) break;
            st++;
            if (st > 50) abort("reach_refill_word2");
        end
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        check("reset_mid_refill_req", 64'(a_mreq), 64'd0);
        check("reset_mid_refill_we", 64'(a_mwe), 64'd0);
        exp_q.delete();
        ref_mem = bmem;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(0, 0, F3_W, 32'h100, 0, st);
        check("miss_after_reset", 64'(st), 64'd5);
        do_op(0, 0, F3_W, 32'h2050, 0, st);

        // Direct-mapped 4-set instance: conflicting tags evict each other
        do_op(1, 0, F3_W, 32'h8000_0000, 0, st);
        check("dm_first_stall", 64'(st), 64'd5);
        do_op(1, 0, F3_W, 32'h8000_0040, 0, st);
        check("dm_conflict_stall", 64'(st), 64'd5);
        do_op(1, 0, F3_W, 32'h8000_0000, 0, st);
        check("dm_alternate_stall", 64'(st), 64'd5);
        do_op(1, 0, F3_W, 32'h8000_0004, 0, st);
        check("dm_hit_stall", 64'(st), 64'd0);
        do_op(1, 1, F3_W, 32'h8000_0108, 32'h8001_1234, st);
        check("dm_store_miss_stall", 64'(st), 64'd5);
        do_op(1, 0, F3_HU, 32'h8000_010A, 0, st);
        do_op(1, 0, F3_H, 32'h8000_0108, 0, st);
        xlog.delete();
        do_op(1, 0, F3_W, 32'h8000_0000, 0, st);
        check("dm_dirty_stall", 64'(st), 64'd9);
        check_line("dm_writeback", 0, 1'b1, 32'h8000_0100);
        do_op(1, 0, F3_W, 32'h8000_0108, 0, st);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        summary_and_finish();
    end

endmodule
